ad_video_source: RTL and testbench
==================================

Name: ad_video_source

Overview:
- Synthesisable AD9980-style video transmitter: generates the hsync/vsync/24-bit RGB stream that the video input stage receives.
- Drives pattern frames into the input path for bring-up and hardware loopback without an analog source.
- Timing fields mirror the CSR set used by the output stage.
- Sits in the pixel clock domain, muxed ahead of the AD9980 input pins.

Parameters:
- SYNC_ACTIVE_LOW, 1, sync outputs active-low when 1, active-high when 0.
- MIN_TOTAL, 4, smallest legal columns_i/lines_i value.

Ports:
- clk_i  in  1  pixel clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- enable_i  in  1  run request.
- h_sync_i  in  10  hsync width, pixels.
- h_bp_i  in  10  horizontal back porch, pixels.
- h_vld_i  in  10  active pixels per line.
- columns_i  in  10  total pixels per line.
- v_sync_i  in  10  vsync width, lines.
- v_bp_i  in  10  vertical back porch, lines.
- v_vld_i  in  10  active lines.
- lines_i  in  10  total lines per frame.
- pattern_sel_i  in  2  0 solid, 1 colour bars, 2 gradient, 3 checker.
- color_i  in  24  solid/checker colour {R,G,B}.
- hsync_o  out  1  horizontal sync.
- vsync_o  out  1  vertical sync.
- red_o  out  8  red pixel data.
- green_o  out  8  green pixel data.
- blue_o  out  8  blue pixel data.
- de_o  out  1  active-pixel flag.
- frame_start_o  out  1  one-cycle pulse at pixel (0,0).
- busy_o  out  1  high in RUN and DRAIN.
- config_err_o  out  1  latched configuration was illegal.

Behaviour:
- Reset, sync: state IDLE, counters 0. All outputs inactive: syncs deasserted at their polarity, RGB 0, de_o/frame_start_o/busy_o/config_err_o 0. Reset mid-frame aborts the frame immediately.
- States:
  - IDLE: enable_i=1 latches all timing, pattern and colour inputs into shadow registers and goes to RUN with h=0, v=0.
  - RUN: enable_i=0 seen goes to DRAIN.
  - DRAIN: completes the current frame; at the last pixel goes to IDLE.
  - In RUN, at the last pixel: shadow registers reload and the frame repeats.
  - Inputs change only take effect at frame boundaries.
- Counters:
  - h counts 0..COLUMNS-1 and wraps to 0.
  - v increments on h wrap and wraps after LINES-1.
- Horizontal regions: sync [0, HS); back porch [HS, HS+HBP); active [HS+HBP, HS+HBP+HVLD); the remainder is front porch. Vertical regions are defined identically.
- Boundary computation:
  - Region boundaries use 11-bit sums.
  - Any boundary above the total is clipped to the total, so truncated active regions are legal.
  - Active x/y are counted from 0 at the first active pixel.
- Illegal configuration: latched COLUMNS or LINES < MIN_TOTAL → config_err_o=1, return to IDLE, no output toggling. config_err_o clears at the next accepted start with a legal configuration.
- Output latency: all outputs are registered and reflect the counter state of the previous cycle. With enable_i high in IDLE at cycle N: counters are (0,0) at N+1; frame_start_o and sync assertion occur at N+2.
- Outside active region: RGB = 0, de_o = 0.
- Patterns:
  - Solid: color_i.
  - Bars: bar width = HVLD>>3; run-length counter, bar index saturates at 7. Order: white, yellow, cyan, green, magenta, red, blue, black (components 0xFF/0x00). If bar width = 0, bar index = 7 (black).
  - Gradient: R=G=B=x[7:0]; wraps every 256 pixels.
  - Checker: (x[3]^y[3]) ? color_i : 0.

Optional Feature:
- Macro: AD_VIDEO_SCROLL_EN.
- Defined: 10-bit offset register, reset 0, increments at each frame end (wraps 1023→0). Gradient and checker use (x+offset)[9:0] in place of x. Offset is cleared on IDLE entry.
- Undefined: patterns static, no offset logic.

Decomposition:
- Shared package: pattern-select encodings, eight bar colour constants, state encoding, MIN_TOTAL default.
- One sub-module, ad_video_timing_core: shadow registers, h/v counters, region flags, frame_start.
- Pattern mux plus output registers stay in the top module.

Test Plan:
- Basic timing: HS=2, HBP=2, HVLD=8, COLUMNS=16, VS=1, VBP=1, VVLD=4, LINES=8, solid 0x123456 → hsync low for 2 cycles every 16. de_o high 8 cycles per line on lines 2–5. RGB=12/34/56 only when de_o high. frame_start_o every 128 cycles. First pulse 2 cycles after enable.
- Colour bars, HVLD=640 → 80 pixels per bar in order white…black. Checks at x=0 (FFFFFF), x=80 (FFFF00), x=639 (000000).
- Mid-frame changes: disable at v=3, then change columns_i → frame completes with old timing, busy_o falls after the last pixel, outputs idle. Re-enable → new timing from (0,0).
- Illegal configuration: COLUMNS=2 → config_err_o=1, busy_o=0, hsync never asserted. Restart with COLUMNS=16 → config_err_o=0, normal output.
- Truncation and reset: HS+HBP+HVLD=20 > COLUMNS=16 → de_o high for columns 4–15 only. rst_i pulsed mid-line → all outputs at reset values next cycle.
- AD_VIDEO_SCROLL_EN, gradient → pixel x=0 reads 0, 1, 2 on frames 0, 1, 2. Without the macro it reads 0 on every frame.

Source files
------------

// File: rtl/ad_video_source_pkg.sv
// Shared encodings and constants for the ad_video_source pattern generator.
package ad_video_source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PAT_SOLID    = 2'd0,
    PAT_BARS     = 2'd1,
    PAT_GRADIENT = 2'd2,
    PAT_CHECKER  = 2'd3
  } pattern_t;

  localparam int unsigned MIN_TOTAL_DEFAULT = 4;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/ad_video_source_timing.sv
// ad_video_timing_core: shadow registers, h/v counters, region flags and frame strobes.
// Optional AD_VIDEO_SCROLL_EN adds a per-frame horizontal offset for scrolling patterns.
module ad_video_timing_core
  import ad_video_source_pkg::*;
#(
  parameter int unsigned MIN_TOTAL = MIN_TOTAL_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [9:0]  h_sync_i,
  input  logic [9:0]  h_bp_i,
  input  logic [9:0]  h_vld_i,
  input  logic [9:0]  columns_i,
  input  logic [9:0]  v_sync_i,
  input  logic [9:0]  v_bp_i,
  input  logic [9:0]  v_vld_i,
  input  logic [9:0]  lines_i,
  input  logic [1:0]  pattern_sel_i,
  input  logic [23:0] color_i,
  output logic        busy,
  output logic        config_err,
  output logic        frame_start,
  output logic        hs_act,
  output logic        vs_act,
  output logic        de,
  output logic [9:0]  x,
  output logic [7:0]  scroll_x,
  output logic        y_bit3,
  output pattern_t    pattern,
  output logic [23:0] color,
  output logic [6:0]  bar_w
);

  localparam logic [9:0] MIN_TOT = MIN_TOTAL[9:0];

  state_t      state;
  logic [9:0]  hs_r, hbp_r, hvld_r, cols_r, vs_r, vbp_r, vvld_r, lines_r;
  logic [9:0]  h_cnt, v_cnt;
  logic        err_r, in_run, h_last, v_last, frame_end, load, legal_in;
  logic [10:0] h_sync_end, h_act_start, h_act_end;
  logic [10:0] v_sync_end, v_act_start, v_act_end;

  function automatic logic [10:0] clip(input logic [10:0] b, input logic [9:0] total);
    return (b > {1'b0, total}) ? {1'b0, total} : b;
  endfunction

  always_comb begin
    h_sync_end  = clip({1'b0, hs_r}, cols_r);
    h_act_start = clip(h_sync_end + {1'b0, hbp_r}, cols_r);
    h_act_end   = clip(h_act_start + {1'b0, hvld_r}, cols_r);
    v_sync_end  = clip({1'b0, vs_r}, lines_r);
    v_act_start = clip(v_sync_end + {1'b0, vbp_r}, lines_r);
    v_act_end   = clip(v_act_start + {1'b0, vvld_r}, lines_r);
  end

  assign in_run      = (state != ST_IDLE);
  assign h_last      = (h_cnt == cols_r - 10'd1);
  assign v_last      = (v_cnt == lines_r - 10'd1);
  assign frame_end   = in_run && h_last && v_last;
  assign frame_start = in_run && (h_cnt == '0) && (v_cnt == '0);
  assign legal_in    = (columns_i >= MIN_TOT) && (lines_i >= MIN_TOT);
  assign load        = enable_i && ((state == ST_IDLE) || (state == ST_RUN && frame_end));

  assign hs_act = in_run && ({1'b0, h_cnt} < h_sync_end);
  assign vs_act = in_run && ({1'b0, v_cnt} < v_sync_end);
  assign de     = in_run && ({1'b0, h_cnt} >= h_act_start) && ({1'b0, h_cnt} < h_act_end)
                         && ({1'b0, v_cnt} >= v_act_start) && ({1'b0, v_cnt} < v_act_end);
  assign x      = h_cnt - h_act_start[9:0];
  // Bit 3 of (v - start) formed from the low bits plus the borrow into bit 3.
  assign y_bit3 = v_cnt[3] ^ v_act_start[3] ^ (v_cnt[2:0] < v_act_start[2:0]);

  assign busy       = in_run;
  assign config_err = err_r;
  assign bar_w      = hvld_r[9:3];

`ifdef AD_VIDEO_SCROLL_EN
  logic [9:0] offset;
  always_ff @(posedge clk_i) begin
    if (rst_i || state == ST_IDLE) offset <= '0;
    else if (frame_end)            offset <= offset + 10'd1;
  end
  assign scroll_x = x[7:0] + offset[7:0];
`else
  assign scroll_x = x[7:0];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {hs_r, hbp_r, hvld_r, cols_r} <= '0;
      {vs_r, vbp_r, vvld_r, lines_r} <= '0;
      pattern <= PAT_SOLID;
      color   <= '0;
    end else if (load) begin
      hs_r    <= h_sync_i;
      hbp_r   <= h_bp_i;
      hvld_r  <= h_vld_i;
      cols_r  <= columns_i;
      vs_r    <= v_sync_i;
      vbp_r   <= v_bp_i;
      vvld_r  <= v_vld_i;
      lines_r <= lines_i;
      pattern <= pattern_t'(pattern_sel_i);
      color   <= color_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
      err_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          h_cnt <= '0;
          v_cnt <= '0;
          if (enable_i) begin
            err_r <= !legal_in;
            if (legal_in) state <= ST_RUN;
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 10'd1;
          end else begin
            h_cnt <= h_cnt + 10'd1;
          end
          if (frame_end) begin
            if (state == ST_RUN && enable_i) begin
              if (!legal_in) begin
                state <= ST_IDLE;
                err_r <= 1'b1;
              end
            end else begin
              state <= ST_IDLE;
            end
          end else if (state == ST_RUN && !enable_i) begin
            state <= ST_DRAIN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ad_video_source.sv
// AD9980-style test video source: pattern mux and registered sync/RGB outputs.
// Define AD_VIDEO_SCROLL_EN to scroll gradient/checker patterns one pixel per frame.
module ad_video_source
  import ad_video_source_pkg::*;
#(
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned MIN_TOTAL       = MIN_TOTAL_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [9:0]  h_sync_i,
  input  logic [9:0]  h_bp_i,
  input  logic [9:0]  h_vld_i,
  input  logic [9:0]  columns_i,
  input  logic [9:0]  v_sync_i,
  input  logic [9:0]  v_bp_i,
  input  logic [9:0]  v_vld_i,
  input  logic [9:0]  lines_i,
  input  logic [1:0]  pattern_sel_i,
  input  logic [23:0] color_i,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [7:0]  red_o,
  output logic [7:0]  green_o,
  output logic [7:0]  blue_o,
  output logic        de_o,
  output logic        frame_start_o,
  output logic        busy_o,
  output logic        config_err_o
);

  localparam logic SYNC_OFF = SYNC_ACTIVE_LOW;

  logic        busy, cfg_err, fs, hs_act, vs_act, de, y_bit3;
  logic [9:0]  x;
  logic [7:0]  scroll_x;
  logic [6:0]  bar_w, bar_cnt, cur_cnt;
  logic [2:0]  bar_idx, cur_idx, pix_idx;
  logic [23:0] color, pix;
  pattern_t    pattern;

  ad_video_timing_core #(.MIN_TOTAL(MIN_TOTAL)) u_timing (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .h_sync_i      (h_sync_i),
    .h_bp_i        (h_bp_i),
    .h_vld_i       (h_vld_i),
    .columns_i     (columns_i),
    .v_sync_i      (v_sync_i),
    .v_bp_i        (v_bp_i),
    .v_vld_i       (v_vld_i),
    .lines_i       (lines_i),
    .pattern_sel_i (pattern_sel_i),
    .color_i       (color_i),
    .busy          (busy),
    .config_err    (cfg_err),
    .frame_start   (fs),
    .hs_act        (hs_act),
    .vs_act        (vs_act),
    .de            (de),
    .x             (x),
    .scroll_x      (scroll_x),
    .y_bit3        (y_bit3),
    .pattern       (pattern),
    .color         (color),
    .bar_w         (bar_w)
  );

  // Run-length bar tracking restarts at the first active pixel of every line.
  always_comb begin
    cur_idx = (x == '0) ? 3'd0 : bar_idx;
    cur_cnt = (x == '0) ? 7'd0 : bar_cnt;
    pix_idx = (bar_w == '0) ? 3'd7 : cur_idx;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bar_idx <= '0;
      bar_cnt <= '0;
    end else if (de) begin
      if (cur_cnt == bar_w - 7'd1) begin
        bar_cnt <= '0;
        bar_idx <= (cur_idx == 3'd7) ? 3'd7 : cur_idx + 3'd1;
      end else begin
        bar_cnt <= cur_cnt + 7'd1;
        bar_idx <= cur_idx;
      end
    end
  end

  always_comb begin
    pix = '0;
    case (pattern)
      PAT_SOLID:    pix = color;
      PAT_BARS:     pix = bar_color(pix_idx);
      PAT_GRADIENT: pix = {scroll_x, scroll_x, scroll_x};
      PAT_CHECKER:  pix = (scroll_x[3] ^ y_bit3) ? color : '0;
      default:      pix = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hsync_o                 <= SYNC_OFF;
      vsync_o                 <= SYNC_OFF;
      {red_o, green_o, blue_o} <= '0;
      de_o                    <= 1'b0;
      frame_start_o           <= 1'b0;
      busy_o                  <= 1'b0;
      config_err_o            <= 1'b0;
    end else begin
      hsync_o                 <= hs_act ? ~SYNC_OFF : SYNC_OFF;
      vsync_o                 <= vs_act ? ~SYNC_OFF : SYNC_OFF;
      {red_o, green_o, blue_o} <= de ? pix : '0;
      de_o                    <= de;
      frame_start_o           <= fs;
      busy_o                  <= busy;
      config_err_o            <= cfg_err;
    end
  end

endmodule

// File: tb/tb_ad_video_source.sv
// Directed self-checking bench for ad_video_source (honours AD_VIDEO_SCROLL_EN).
module tb_ad_video_source;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, enable_i = 1'b0;
  logic [9:0]  h_sync_i = '0, h_bp_i = '0, h_vld_i = '0, columns_i = '0;
  logic [9:0]  v_sync_i = '0, v_bp_i = '0, v_vld_i = '0, lines_i = '0;
  logic [1:0]  pattern_sel_i = '0;
  logic [23:0] color_i = '0;
  logic        hsync_o, vsync_o, de_o, frame_start_o, busy_o, config_err_o;
  logic [7:0]  red_o, green_o, blue_o;

  int n_cmp = 0;
  int n_bad = 0;
  int c_hs, c_hbp, c_hvld, c_cols, c_vs, c_vbp, c_vvld, c_lines;
  logic [1:0]  c_pat;
  logic [23:0] c_col;
  logic [28:0] got, e;

`ifdef AD_VIDEO_SCROLL_EN
  localparam int SCROLL = 1;
`else
  localparam int SCROLL = 0;
`endif
  localparam logic [28:0] IDLE_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0};

  always #5 clk = ~clk;

  ad_video_source #(.SYNC_ACTIVE_LOW(1'b1), .MIN_TOTAL(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
    .h_sync_i(h_sync_i), .h_bp_i(h_bp_i), .h_vld_i(h_vld_i), .columns_i(columns_i),
    .v_sync_i(v_sync_i), .v_bp_i(v_bp_i), .v_vld_i(v_vld_i), .lines_i(lines_i),
    .pattern_sel_i(pattern_sel_i), .color_i(color_i),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .de_o(de_o), .frame_start_o(frame_start_o), .busy_o(busy_o), .config_err_o(config_err_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
    got = {busy_o, hsync_o, vsync_o, de_o, frame_start_o, red_o, green_o, blue_o};
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    enable_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic set_cfg(input int hs, hbp, hvld, cols, vs, vbp, vvld, lines,
                         input logic [1:0] pat, input logic [23:0] col);
    h_sync_i = 10'(hs);  h_bp_i = 10'(hbp);  h_vld_i = 10'(hvld);  columns_i = 10'(cols);
    v_sync_i = 10'(vs);  v_bp_i = 10'(vbp);  v_vld_i = 10'(vvld);  lines_i = 10'(lines);
    pattern_sel_i = pat; color_i = col;
    c_hs = hs; c_hbp = hbp; c_hvld = hvld; c_cols = cols;
    c_vs = vs; c_vbp = vbp; c_vvld = vvld; c_lines = lines;
    c_pat = pat; c_col = col;
  endtask

  function automatic logic [23:0] bar_rgb(input int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Expected {busy, hsync, vsync, de, frame_start, rgb} for running pixel index p.
  function automatic logic [28:0] exp_vec(input int p, input int off);
    int h, v, x, y, bw, bi;
    logic de;
    logic [7:0] g;
    logic [23:0] rgb;
    h = p % c_cols;
    v = (p / c_cols) % c_lines;
    de = (h >= c_hs + c_hbp) && (h < c_hs + c_hbp + c_hvld) &&
         (v >= c_vs + c_vbp) && (v < c_vs + c_vbp + c_vvld);
    x = h - c_hs - c_hbp;
    y = v - c_vs - c_vbp;
    rgb = 24'h0;
    if (de) begin
      case (c_pat)
        2'd0: rgb = c_col;
        2'd1: begin
          bw = c_hvld / 8;
          bi = (bw == 0) ? 7 : x / bw;
          if (bi > 7) bi = 7;
          rgb = bar_rgb(bi);
        end
        2'd2: begin
          g = 8'((x + off) % 256);
          rgb = {g, g, g};
        end
        default: rgb = ((((x + off) / 8) % 2) != ((y / 8) % 2)) ? c_col : 24'h0;
      endcase
    end
    return {1'b1, !(h < c_hs), !(v < c_vs), de, (h == 0 && v == 0), rgb};
  endfunction

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    n_cmp++;
    if (got !== IDLE_VEC || config_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset got=%h err=%b exp=%h err=0", got, config_err_o, IDLE_VEC);
    end
    do_reset();
  endtask

  task automatic test_basic_timing();
    do_reset();
    set_cfg(2, 2, 8, 16, 1, 1, 4, 8, 2'd0, 24'h123456);
    enable_i = 1'b1;
    step();
    n_cmp++;
    if (frame_start_o !== 1'b0 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_latency fs=%b busy=%b exp fs=0 busy=0", frame_start_o, busy_o);
    end
    for (int p = 0; p < 256; p++) begin
      step();
      e = exp_vec(p, 0);
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL basic p=%0d got=%h exp=%h", p, got, e);
      end
    end
  endtask

  task automatic test_mid_frame();
    do_reset();
    set_cfg(2, 2, 8, 16, 1, 1, 4, 8, 2'd0, 24'h123456);
    enable_i = 1'b1;
    step();
    for (int p = 0; p < 128; p++) begin
      step();
      e = exp_vec(p, 0);
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL drain p=%0d got=%h exp=%h", p, got, e);
      end
      if (p == 48) begin
        enable_i = 1'b0;
        columns_i = 10'd20;
      end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (got !== IDLE_VEC) begin
        n_bad++;
        $display("FAIL drain_idle i=%0d got=%h exp=%h", i, got, IDLE_VEC);
      end
    end
    c_cols = 20;
    enable_i = 1'b1;
    step();
    for (int p = 0; p <= 160; p++) begin
      step();
      e = exp_vec(p, 0);
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL restart20 p=%0d got=%h exp=%h", p, got, e);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    set_cfg(2, 2, 8, 2, 1, 1, 4, 8, 2'd0, 24'h123456);
    enable_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if (hsync_o !== 1'b1 || busy_o !== 1'b0 || de_o !== 1'b0 || config_err_o !== (i >= 1)) begin
        n_bad++;
        $display("FAIL illegal i=%0d hs=%b busy=%b de=%b err=%b exp hs=1 busy=0 de=0 err=%b",
                 i, hsync_o, busy_o, de_o, config_err_o, (i >= 1));
      end
    end
    enable_i = 1'b0;
    columns_i = 10'd16;
    c_cols = 16;
    step();
    n_cmp++;
    if (config_err_o !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_sticky err=%b exp=1", config_err_o);
    end
    enable_i = 1'b1;
    step();
    for (int p = 0; p < 128; p++) begin
      step();
      e = exp_vec(p, 0);
      n_cmp++;
      if (got !== e || config_err_o !== 1'b0) begin
        n_bad++;
        $display("FAIL illegal_recover p=%0d got=%h err=%b exp=%h err=0", p, got, config_err_o, e);
      end
    end
  endtask

  task automatic test_truncation_reset();
    do_reset();
    set_cfg(2, 2, 16, 16, 1, 1, 4, 8, 2'd0, 24'h123456);
    enable_i = 1'b1;
    step();
    for (int p = 0; p <= 164; p++) begin
      step();
      e = exp_vec(p, 0);
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL trunc p=%0d got=%h exp=%h", p, got, e);
      end
    end
    rst_i = 1'b1;
    step();
    n_cmp++;
    if (got !== IDLE_VEC || config_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL midline_reset got=%h err=%b exp=%h err=0", got, config_err_o, IDLE_VEC);
    end
    rst_i = 1'b0;
    enable_i = 1'b0;
    step();
    n_cmp++;
    if (got !== IDLE_VEC) begin
      n_bad++;
      $display("FAIL post_reset_idle got=%h exp=%h", got, IDLE_VEC);
    end
  endtask

  task automatic test_bars();
    do_reset();
    set_cfg(4, 4, 640, 660, 1, 1, 2, 4, 2'd1, 24'h0);
    enable_i = 1'b1;
    step();
    for (int p = 0; p < 2640; p++) begin
      step();
      e = exp_vec(p, 0);
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL bars p=%0d got=%h exp=%h", p, got, e);
      end
    end
    do_reset();
    set_cfg(2, 2, 5, 16, 1, 1, 4, 8, 2'd1, 24'h0);
    enable_i = 1'b1;
    step();
    for (int p = 0; p < 128; p++) begin
      step();
      e = exp_vec(p, 0);
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL bars_w0 p=%0d got=%h exp=%h", p, got, e);
      end
    end
  endtask

  task automatic test_gradient_scroll();
    do_reset();
    set_cfg(2, 2, 8, 16, 1, 1, 4, 8, 2'd2, 24'h0);
    enable_i = 1'b1;
    step();
    for (int p = 0; p < 384; p++) begin
      step();
      e = exp_vec(p, SCROLL * (p / 128));
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL gradient p=%0d got=%h exp=%h", p, got, e);
      end
    end
  endtask

  task automatic test_checker();
    do_reset();
    set_cfg(1, 1, 30, 40, 1, 1, 20, 24, 2'd3, 24'hABCDEF);
    enable_i = 1'b1;
    step();
    for (int p = 0; p < 960; p++) begin
      step();
      e = exp_vec(p, 0);
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL checker p=%0d got=%h exp=%h", p, got, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_timing();
    test_mid_frame();
    test_illegal();
    test_truncation_reset();
    test_bars();
    test_gradient_scroll();
    test_checker();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
